vend_sequencer: RTL

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// Vending sequencer: tracks credit from inserted coins, arbitrates cancel /
// selection / coin / timeout events, drives the dispense mechanism, pays out
// change and latches a fault when dispensing takes too long. Every output is
// a register, so each response appears one clock after its cause.
module vend_sequencer #(
    parameter int PRICE0       = 10,
    parameter int PRICE1       = 15,
    parameter int PRICE2       = 20,
    parameter int PRICE3       = 25,
    parameter int PAY_TIMEOUT  = 30,
    parameter int DISP_TIMEOUT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [7:0] coin_value,
    input  logic       sel_valid,
    input  logic [1:0] item_sel,
    input  logic       cancel,
    input  logic       dispense_done,
    input  logic [5:0] time_end,
    output logic       counting_sign,
    output logic [2:0] state,
    output logic [7:0] credit,
    output logic       dispense_en,
    output logic [1:0] item_out,
    output logic       change_valid,
    output logic [7:0] change_amount,
    output logic       coin_reject,
    output logic       deny,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PAY      = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    localparam logic [5:0] PAY_TO  = 6'(PAY_TIMEOUT);
    localparam logic [5:0] DISP_TO = 6'(DISP_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [1:0] item_q, item_d;
    logic       count_q, count_d;
    logic       disp_en_q, disp_en_d;
    logic       change_valid_q, change_valid_d;
    logic [7:0] change_amount_q, change_amount_d;
    logic       coin_reject_q, coin_reject_d;
    logic       deny_q, deny_d;
    logic       fault_q, fault_d;

    logic       timer_restart;
    logic [7:0] price_sel;
    logic [8:0] coin_sum;
    logic       coin_ovf;

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_ovf = coin_sum[8];

    // Price lookup for the item currently being selected
    always_comb begin
        price_sel = 8'(PRICE0);
        case (item_sel)
            2'd0:    price_sel = 8'(PRICE0);
            2'd1:    price_sel = 8'(PRICE1);
            2'd2:    price_sel = 8'(PRICE2);
            default: price_sel = 8'(PRICE3);
        endcase
    end

    // State and output registers, cleared synchronously by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            credit_q        <= 8'd0;
            item_q          <= 2'd0;
            count_q         <= 1'b0;
            disp_en_q       <= 1'b0;
            change_valid_q  <= 1'b0;
            change_amount_q <= 8'd0;
            coin_reject_q   <= 1'b0;
            deny_q          <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            item_q          <= item_d;
            count_q         <= count_d;
            disp_en_q       <= disp_en_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            coin_reject_q   <= coin_reject_d;
            deny_q          <= deny_d;
            fault_q         <= fault_d;
        end
    end

    // Next-state logic: one event per cycle, highest-priority event wins
    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        item_d          = item_q;
        change_amount_d = change_amount_q;
        coin_reject_d   = 1'b0;
        deny_d          = 1'b0;
        timer_restart   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (coin_valid) begin
                    if (coin_ovf) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[7:0];
                        state_d  = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    state_d       = S_CHANGE;
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (credit_q >= price_sel) begin
                        credit_d = credit_q - price_sel;
                        item_d   = item_sel;
                        state_d  = S_DISPENSE;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ovf) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d      = coin_sum[7:0];
                        timer_restart = 1'b1;
                    end
                end else if (count_q && (time_end >= PAY_TO)) begin
                    state_d = S_CHANGE;
                end
            end
            S_DISPENSE: begin
                coin_reject_d = coin_valid;
                if (dispense_done) begin
                    state_d = (credit_q != 8'd0) ? S_CHANGE : S_IDLE;
                end else if (count_q && (time_end >= DISP_TO)) begin
                    // Gated by count_q: during the restart cycle time_end may
                    // still show the stale PAY count.
                    state_d = S_FAULT;
                end
            end
            S_CHANGE: begin
                coin_reject_d = coin_valid;
                credit_d      = 8'd0;
                state_d       = S_IDLE;
            end
            S_FAULT: begin
                coin_reject_d = coin_valid;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any entry into PAY or DISPENSE also restarts the external timer
        if ((state_d != state_q) && ((state_d == S_PAY) || (state_d == S_DISPENSE))) begin
            timer_restart = 1'b1;
        end

        // Change payout captures the credit remaining at entry to CHANGE
        if (state_d == S_CHANGE) begin
            change_amount_d = credit_d;
        end
    end

    // Registered output values derived from the upcoming state
    always_comb begin
        count_d        = ((state_d == S_PAY) || (state_d == S_DISPENSE)) && !timer_restart;
        disp_en_d      = (state_d == S_DISPENSE);
        change_valid_d = (state_d == S_CHANGE);
        fault_d        = (state_d == S_FAULT);
    end

    // Drive ports from registers
    always_comb begin
        state         = state_q;
        credit        = credit_q;
        item_out      = item_q;
        counting_sign = count_q;
        dispense_en   = disp_en_q;
        change_valid  = change_valid_q;
        change_amount = change_amount_q;
        coin_reject   = coin_reject_q;
        deny          = deny_q;
        fault         = fault_q;
    end

endmodule
